// File: rtl/main_memory_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module : main_memory_arbiter_pkg
// Brief  : Shared architecture constants: pipeline stages, instruction types,
//          memory arbiter FSM encodings and requester identifiers.
// Rev    : 1.0
//==============================================================================
package main_memory_arbiter_pkg;

   typedef enum logic [2:0] {
      STAGE_IF  = 3'd0,
      STAGE_ID  = 3'd1,
      STAGE_EX  = 3'd2,
      STAGE_MEM = 3'd3,
      STAGE_WB  = 3'd4
   } pipe_stage_t;

   typedef enum logic [1:0] {
      ITYPE_ALU    = 2'd0,
      ITYPE_LOAD   = 2'd1,
      ITYPE_STORE  = 2'd2,
      ITYPE_BRANCH = 2'd3
   } instr_type_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      WRITE     = 2'd2,
      RESPOND   = 2'd3
   } mem_state_t;

   localparam logic c_owner_fetch   = 1'b0;
   localparam logic c_owner_data    = 1'b1;
   localparam int   c_lat_cnt_width = 4;

   // Counter preload so that the last READ_WAIT cycle is the one with count 0.
   function automatic logic [c_lat_cnt_width-1:0] latency_preload(input int latency);
      return c_lat_cnt_width'(latency - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/main_memory_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module : main_memory_arbiter_if
// Brief  : Fetch, data-stage and main-memory signals of the memory arbiter.
// Rev    : 1.0
//==============================================================================
interface main_memory_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic        if_valid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_valid;
   logic [31:0] d_rdata;

   logic [31:0] mem_read_address;
   logic [31:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;

   modport slave (
      input  if_req, if_addr,
      output if_ready, if_valid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ready, d_valid, d_rdata,
      output mem_read_address, mem_write_address, mem_write_data, mem_write_enable,
      input  mem_read_data
   );

   modport master (
      output if_req, if_addr,
      input  if_ready, if_valid, if_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ready, d_valid, d_rdata,
      input  mem_read_address, mem_write_address, mem_write_data, mem_write_enable,
      output mem_read_data
   );

endinterface
`default_nettype wire

// File: rtl/main_memory_arbiter_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module : mem_rr_arbiter
// Brief  : Two-input round-robin arbiter (fetch vs. data) with a registered
//          last-grant bit; a tie goes to the requester not granted last.
// Rev    : 1.0
//==============================================================================
module mem_rr_arbiter
   import main_memory_arbiter_pkg::*;
(
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_en,
   input  wire logic i_req_fetch,
   input  wire logic i_req_data,
   output logic      o_gnt_fetch,
   output logic      o_gnt_data
);

   logic r_last;

   always_comb begin
      o_gnt_fetch = 1'b0;
      o_gnt_data  = 1'b0;
      if (i_en) begin
         if (i_req_fetch && i_req_data) begin
            o_gnt_fetch = (r_last == c_owner_data);
            o_gnt_data  = (r_last == c_owner_fetch);
         end else begin
            o_gnt_fetch = i_req_fetch;
            o_gnt_data  = i_req_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= c_owner_fetch;
      end else if (o_gnt_data) begin
         r_last <= c_owner_data;
      end else if (o_gnt_fetch) begin
         r_last <= c_owner_fetch;
      end
   end

endmodule
`default_nettype wire

// File: rtl/main_memory_arbiter.sv
`default_nettype none
//==============================================================================
// Module : main_memory_arbiter
// Brief  : Shares one main-memory port between instruction fetch and the data
//          stage, one transaction outstanding at a time.
// Rev    : 1.0
//==============================================================================
module main_memory_arbiter
   import main_memory_arbiter_pkg::*;
#(
   parameter int READ_LATENCY = 1
)(
   input  wire logic            clk,
   input  wire logic            rst,
   main_memory_arbiter_if.slave bus
);

   mem_state_t                 r_state;
   mem_state_t                 w_state_next;
   logic                       r_owner;
   logic [31:0]                r_addr;
   logic [31:0]                r_wdata;
   logic [31:0]                r_if_rdata;
   logic [31:0]                r_d_rdata;
   logic [c_lat_cnt_width-1:0] r_cnt;

   logic w_arb_en;
   logic w_gnt_fetch;
   logic w_gnt_data;
   logic w_accept;
   logic w_if_ready;
   logic w_d_ready;
   logic w_if_valid;
   logic w_d_valid;
   logic w_mem_we;

   // Gating with rst keeps ready low while reset is held.
   assign w_arb_en = (r_state == IDLE) && !rst;
   assign w_accept = w_gnt_fetch | w_gnt_data;

   mem_rr_arbiter u_arbiter (
      .clk         (clk),
      .rst         (rst),
      .i_en        (w_arb_en),
      .i_req_fetch (bus.if_req),
      .i_req_data  (bus.d_req),
      .o_gnt_fetch (w_gnt_fetch),
      .o_gnt_data  (w_gnt_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_if_ready   = 1'b0;
      w_d_ready    = 1'b0;
      w_if_valid   = 1'b0;
      w_d_valid    = 1'b0;
      w_mem_we     = 1'b0;
      case (r_state)
         IDLE: begin
            w_if_ready = w_gnt_fetch;
            w_d_ready  = w_gnt_data;
            if (w_gnt_fetch) begin
               w_state_next = READ_WAIT;
            end else if (w_gnt_data) begin
               w_state_next = bus.d_we ? WRITE : READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (r_cnt == '0) begin
               w_state_next = RESPOND;
            end
         end
         WRITE: begin
            w_mem_we     = 1'b1;
            w_state_next = RESPOND;
         end
         RESPOND: begin
            w_if_valid   = (r_owner == c_owner_fetch);
            w_d_valid    = (r_owner == c_owner_data);
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner    <= c_owner_fetch;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_owner <= w_gnt_data ? c_owner_data : c_owner_fetch;
         r_addr  <= w_gnt_data ? bus.d_addr : bus.if_addr;
         if (w_gnt_data) begin
            r_wdata <= bus.d_wdata;
         end
         r_cnt <= latency_preload(READ_LATENCY);
      end else if (r_state == READ_WAIT) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else if (r_owner == c_owner_data) begin
            r_d_rdata <= bus.mem_read_data;
         end else begin
            r_if_rdata <= bus.mem_read_data;
         end
      end
   end

   assign bus.if_ready          = w_if_ready;
   assign bus.d_ready           = w_d_ready;
   assign bus.if_valid          = w_if_valid;
   assign bus.d_valid           = w_d_valid;
   assign bus.if_rdata          = r_if_rdata;
   assign bus.d_rdata           = r_d_rdata;
   assign bus.mem_read_address  = r_addr;
   assign bus.mem_write_address = r_addr;
   assign bus.mem_write_data    = r_wdata;
   assign bus.mem_write_enable  = w_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_arbiter.sv
`default_nettype none
//==============================================================================
// Module : tb_main_memory_arbiter
// Brief  : Self-checking bench: RL=1 and RL=3 instances with memory models.
// Rev    : 1.0
//==============================================================================
module tb_main_memory_arbiter;

   typedef struct packed {
      logic        is_data;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic        owner;
      int          exp_cyc;
      logic        chk;
      logic [31:0] data;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   sb_t  sb1[$];
   sb_t  sb3[$];
   sb_t  e1;
   sb_t  e3;
   vec_t vecs[9];

   logic [31:0] last_if;
   logic [31:0] last_d;

   main_memory_arbiter_if bus1();
   main_memory_arbiter_if bus3();

   main_memory_arbiter #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   main_memory_arbiter #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory models: RL=1 is combinational, RL=3 delays data by two edges.
   logic [31:0] mem1 [0:255];
   logic [31:0] mem3 [0:255];
   logic [31:0] s0, s1;
   logic        mem_init_done = 1'b0;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) begin
            mem1[i] <= 32'hA5A5_0000 | i;
            mem3[i] <= 32'hA5A5_0000 | i;
         end
         mem1[8'h40]   <= 32'h0000_1234;
         mem1[8'h44]   <= 32'h0000_5678;
         mem_init_done <= 1'b1;
      end else begin
         if (bus1.mem_write_enable) mem1[bus1.mem_write_address[7:0]] <= bus1.mem_write_data;
         if (bus3.mem_write_enable) mem3[bus3.mem_write_address[7:0]] <= bus3.mem_write_data;
      end
      s0 <= mem3[bus3.mem_read_address[7:0]];
      s1 <= s0;
   end

   assign bus1.mem_read_data = mem1[bus1.mem_read_address[7:0]];
   assign bus3.mem_read_data = s1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (!rst && (bus1.if_valid || bus1.d_valid)) begin
         if (sb1.size() == 0) begin
            check("m1_unexpected_valid", 32'({bus1.if_valid, bus1.d_valid}), 32'd0);
         end else begin
            e1 = sb1.pop_front();
            check("m1_valid_onehot", 32'(bus1.if_valid & bus1.d_valid), 32'd0);
            check("m1_owner", 32'(bus1.d_valid), 32'(e1.owner));
            check("m1_cycle", 32'(cyc), 32'(e1.exp_cyc));
            if (e1.chk) check("m1_rdata", e1.owner ? bus1.d_rdata : bus1.if_rdata, e1.data);
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (!rst && (bus3.if_valid || bus3.d_valid)) begin
         if (sb3.size() == 0) begin
            check("m3_unexpected_valid", 32'({bus3.if_valid, bus3.d_valid}), 32'd0);
         end else begin
            e3 = sb3.pop_front();
            check("m3_owner", 32'(bus3.d_valid), 32'(e3.owner));
            check("m3_cycle", 32'(cyc), 32'(e3.exp_cyc));
            if (e3.chk) check("m3_rdata", e3.owner ? bus3.d_rdata : bus3.if_rdata, e3.data);
         end
      end
   end

   task automatic wait_accept1(input logic owner, output int t);
      t = -1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (owner ? bus1.d_ready : bus1.if_ready) begin
            t = cyc;
            break;
         end
         @(negedge clk);
      end
      check("accept_within_bound", 32'(t >= 0), 32'd1);
   endtask

   task automatic drain(input logic which);
      for (int k = 0; k < 30; k++) begin
         if ((which ? sb3.size() : sb1.size()) == 0) break;
         @(negedge clk);
      end
      check("drain_empty", 32'(which ? sb3.size() : sb1.size()), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int   t;
      logic store;
      store = v.is_data & v.we;
      @(negedge clk);
      bus1.if_req  = ~v.is_data;
      bus1.d_req   = v.is_data;
      bus1.if_addr = v.addr;
      bus1.d_addr  = v.addr;
      bus1.d_we    = v.we;
      bus1.d_wdata = v.wdata;
      wait_accept1(v.is_data, t);
      if (t < 0) begin
         bus1.if_req = 1'b0;
         bus1.d_req  = 1'b0;
         return;
      end
      sb1.push_back('{v.is_data, t + 2, ~store, v.exp});
      @(negedge clk);
      bus1.if_req  = 1'b0;
      bus1.d_req   = 1'b0;
      bus1.if_addr = ~v.addr;
      bus1.d_addr  = ~v.addr;
      bus1.d_wdata = ~v.wdata;
      bus1.d_we    = ~v.we;
      #1;
      if (store) begin
         check("vec_we_t1", 32'(bus1.mem_write_enable), 32'd1);
         check("vec_waddr_t1", bus1.mem_write_address, v.addr);
         check("vec_wdata_t1", bus1.mem_write_data, v.wdata);
      end else begin
         check("vec_raddr_t1", bus1.mem_read_address, v.addr);
         check("vec_we_read", 32'(bus1.mem_write_enable), 32'd0);
      end
      @(negedge clk);
      #1;
      check("vec_we_t2", 32'(bus1.mem_write_enable), 32'd0);
      @(negedge clk);
      #1;
      if (!store) begin
         if (v.is_data) last_d = v.exp;
         else           last_if = v.exp;
      end
      check("vec_if_rdata_hold", bus1.if_rdata, last_if);
      check("vec_d_rdata_hold", bus1.d_rdata, last_d);
      bus1.d_we = 1'b0;
   endtask

   initial begin
      int   t;
      int   last_t;
      int   grants;
      logic owner;

      bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0;
      bus1.d_we = 1'b0;   bus1.d_addr = '0;  bus1.d_wdata = '0;
      bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0;
      bus3.d_we = 1'b0;   bus3.d_addr = '0;  bus3.d_wdata = '0;
      last_if = '0;
      last_d  = '0;

      vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'h0000_1234};
      vecs[1] = '{1'b1, 1'b1, 32'h80, 32'h0000_DEAD, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h80, 32'h0,         32'h0000_DEAD};
      vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'h0000_5678};
      vecs[4] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hA5A5_0010};
      vecs[5] = '{1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 32'h0};
      vecs[6] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h0BAD_F00D};
      vecs[7] = '{1'b0, 1'b1, 32'h80, 32'hFFFF_0000, 32'h0000_DEAD};
      vecs[8] = '{1'b1, 1'b0, 32'h80, 32'h0,         32'h0000_DEAD};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_ctrl", 32'({bus1.if_ready, bus1.d_ready, bus1.if_valid, bus1.d_valid,
                             bus1.mem_write_enable}), 32'd0);
      check("rst_raddr", bus1.mem_read_address, 32'd0);
      check("rst_waddr", bus1.mem_write_address, 32'd0);
      check("rst_wdata", bus1.mem_write_data, 32'd0);
      check("rst_rdata", bus1.if_rdata | bus1.d_rdata, 32'd0);
      check("rst_raddr3", bus3.mem_read_address, 32'd0);
      bus1.if_req = 1'b1;
      bus1.d_req  = 1'b1;
      #1;
      check("rst_ready_gated", 32'({bus1.if_ready, bus1.d_ready}), 32'd0);
      bus1.if_req = 1'b0;
      bus1.d_req  = 1'b0;

      // Both requesters rise right after reset and stay high: data, fetch, ...
      @(negedge clk);
      rst          = 1'b0;
      bus1.if_req  = 1'b1;
      bus1.d_req   = 1'b1;
      bus1.if_addr = 32'h40;
      bus1.d_addr  = 32'h44;
      bus1.d_we    = 1'b0;
      grants = 0;
      last_t = -1;
      for (int k = 0; k < 40 && grants < 6; k++) begin
         #1;
         if (bus1.if_ready || bus1.d_ready) begin
            check("alt_ready_onehot", 32'(bus1.if_ready & bus1.d_ready), 32'd0);
            owner = bus1.d_ready;
            check("alt_grant_owner", 32'(owner), 32'((grants % 2) == 0));
            if (last_t >= 0) check("alt_grant_spacing", 32'(cyc - last_t), 32'd3);
            sb1.push_back('{owner, cyc + 2, 1'b1, owner ? 32'h0000_5678 : 32'h0000_1234});
            grants++;
            last_t = cyc;
         end
         @(negedge clk);
      end
      check("alt_grant_count", 32'(grants), 32'd6);
      bus1.if_req = 1'b0;
      bus1.d_req  = 1'b0;
      drain(1'b0);
      last_if = 32'h0000_1234;
      last_d  = 32'h0000_5678;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);
      drain(1'b0);

      // Reset one cycle into a store: no write, no d_valid
      @(negedge clk);
      bus1.d_req   = 1'b1;
      bus1.d_we    = 1'b1;
      bus1.d_addr  = 32'h90;
      bus1.d_wdata = 32'h0000_5555;
      wait_accept1(1'b1, t);
      @(negedge clk);
      bus1.d_req = 1'b0;
      bus1.d_we  = 1'b0;
      #1;
      check("rst_mid_we_before", 32'(bus1.mem_write_enable), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_we_after", 32'(bus1.mem_write_enable), 32'd0);
      check("rst_mid_valid", 32'(bus1.d_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_mid_no_write", mem1[8'h90], 32'hA5A5_0090);
      last_if = '0;
      last_d  = '0;
      run_vec('{1'b1, 1'b0, 32'h90, 32'h0, 32'hA5A5_0090});
      drain(1'b0);

      // RL=3 load with the request held through the transaction
      @(negedge clk);
      bus3.d_req  = 1'b1;
      bus3.d_we   = 1'b0;
      bus3.d_addr = 32'h10;
      t = -1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (bus3.d_ready) begin
            t = cyc;
            break;
         end
         @(negedge clk);
      end
      check("r3_accept", 32'(t >= 0), 32'd1);
      sb3.push_back('{1'b1, t + 4, 1'b1, 32'hA5A5_0010});
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) bus3.d_addr = 32'h20;
         #1;
         check("r3_ready_blocked", 32'(bus3.d_ready), 32'd0);
         if (k <= 3) check("r3_raddr_stable", bus3.mem_read_address, 32'h10);
      end
      @(negedge clk);
      #1;
      check("r3_ready_after_idle", 32'(bus3.d_ready), 32'd1);
      sb3.push_back('{1'b1, cyc + 4, 1'b1, 32'hA5A5_0020});
      @(negedge clk);
      bus3.d_req = 1'b0;
      drain(1'b1);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
